// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Pin-side and byte-side signal bundle of the UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_rxd;
    logic                    uart_rx_en;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_valid;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_break;

    // master: pad driver and byte consumer; slave: the receiver itself
    modport master (
        output uart_rxd,
        output uart_rx_en,
        input  uart_rx_data,
        input  uart_rx_valid,
        input  uart_rx_frame_err,
        input  uart_rx_break
    );

    modport slave (
        input  uart_rxd,
        input  uart_rx_en,
        output uart_rx_data,
        output uart_rx_valid,
        output uart_rx_frame_err,
        output uart_rx_break
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling, framing-error and break flags.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 115_200,
    parameter int PAYLOAD_BITS = 8
) (
    input  wire logic clk,
    input  wire logic resetn,
    uart_rx_if.slave  uart
);
    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] C_CNT_FULL  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_HALF  = CNT_W'(HALF_BIT - 1);
    localparam logic [3:0]       C_BITS_LAST = 4'(PAYLOAD_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 4 || PAYLOAD_BITS < 2 || PAYLOAD_BITS > 16) begin : g_bad_cfg
            $error("uart_rx: CLK_FREQ/BAUD must be >= 4 and PAYLOAD_BITS within 2..16");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t                  state_q;
    logic [1:0]              sync_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [3:0]              bit_cnt_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    valid_q;
    logic                    frame_err_q;
    logic                    break_q;
    logic                    rxd_s;
    logic [CNT_W-1:0]        cnt_d;

    assign rxd_s = sync_q[1];
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart.uart_rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            cnt_q       <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    if (!rxd_s && uart.uart_rx_en) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == C_CNT_HALF) begin
                        cnt_q   <= '0;
                        // A start bit that is high again at mid-bit is a glitch
                        state_q <= rxd_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == C_CNT_FULL) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == C_BITS_LAST) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_q == C_CNT_FULL) begin
                        cnt_q <= '0;
                        if (rxd_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            break_q     <= (shift_q == '0);
                            state_q     <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // Held-low line must return high before a new start is accepted
                    cnt_q <= '0;
                    if (rxd_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uart.uart_rx_data      = data_q;
    assign uart.uart_rx_valid     = valid_q;
    assign uart.uart_rx_frame_err = frame_err_q;
    assign uart.uart_rx_break     = break_q;
endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the design's UART transmitter. It samples the asynchronous `uart_rxd` pin and reassembles 8N1 frames, LSB first, at the same `CLK_FREQ`/`BAUD` configuration as the transmitter. Each completed byte is presented with a one-cycle valid pulse, and framing errors and line breaks are flagged. It sits between the pad and the core's peripheral bus or FIFO.

## Interface

Parameters:
- `CLK_FREQ`, default 12_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line bit rate.
- `PAYLOAD_BITS`, default 8: data bits per frame.

Derived values:
- `CYCLES_PER_BIT` = `CLK_FREQ`/`BAUD`, integer division; 104 at the defaults.
- `HALF_BIT` = `CYCLES_PER_BIT`/2; 52 at the defaults.
- `CYCLES_PER_BIT` < 4 is an elaboration error.

Ports (reset resetn, synchronous, active-low; clock clk):
- `clk` in 1: system clock.
- `resetn` in 1: synchronous active-low reset.
- `uart_rxd` in 1: asynchronous serial input; idles high.
- `uart_rx_en` in 1: enables detection of new start bits.
- `uart_rx_data` out `PAYLOAD_BITS`: last good byte. Holds its value until the next good frame.
- `uart_rx_valid` out 1: one-cycle pulse when `uart_rx_data` updates.
- `uart_rx_frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `uart_rx_break` out 1: one-cycle pulse, coincident with `uart_rx_frame_err`, when all data bits and the stop bit were 0.

## Operation

- **Synchroniser:** 2-flop synchroniser on `uart_rxd`, reset to 1. All logic uses the synchronised signal `rxd_s`.
- **Counters:**
  - Cycle counter is `$clog2(CYCLES_PER_BIT)+1` bits. It clears on every state entry and on every sample point, and increments otherwise.
  - Bit counter is 4 bits.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** `rxd_s`==0 && `uart_rx_en` → START.
  - **START:** at count `HALF_BIT`-1, sample `rxd_s`. If 0 → DATA. If 1 → IDLE (glitch rejected; no outputs).
  - **DATA:** at count `CYCLES_PER_BIT`-1, shift `rxd_s` into the shift register MSB (shift right) and increment the bit counter. After the `PAYLOAD_BITS`-th sample → STOP.
  - **STOP:** at count `CYCLES_PER_BIT`-1, sample `rxd_s`.
    - 1: load `uart_rx_data` from the shift register, pulse `uart_rx_valid`, → IDLE.
    - 0: pulse `uart_rx_frame_err`, and also pulse `uart_rx_break` if the shift register is all zero. `uart_rx_data` is unchanged. → WAIT_HIGH.
  - **WAIT_HIGH:** `rxd_s`==1 → IDLE. This prevents a held-low line from retriggering.
  - Unused state encodings → IDLE.
- **`uart_rx_en`:** sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- **Reset values:**
  - `uart_rx_data` = 0; `uart_rx_valid`, `uart_rx_frame_err`, `uart_rx_break` = 0.
  - FSM = IDLE; counters and shift register = 0; synchroniser = 1.
- **Reset mid-frame:** the partial frame is discarded with no pulses. The next frame is received normally.

## Timing

- Pin to `rxd_s` latency: 2 cycles.
- Take cycle 0 as the IDLE cycle in which `rxd_s` is first low. Then:
  - start sample at cycle `HALF_BIT` (52);
  - data bit k (k=0..7) sampled at cycle `HALF_BIT`+(k+1)·`CYCLES_PER_BIT`;
  - stop sample at cycle `HALF_BIT`+9·`CYCLES_PER_BIT` (988);
  - `uart_rx_valid` or `uart_rx_frame_err` is high in cycle 989 only.
- `uart_rx_data` changes in the same cycle `uart_rx_valid` rises and is stable thereafter.
- Back-to-back frames with zero idle time are received. The FSM is in IDLE from mid-stop-bit, so the next start edge is seen.
- Sample points sit within ±1 cycle of bit centre, plus synchroniser delay. Tolerated baud mismatch is at least ±2% at the defaults.
- There is no backpressure. A consumer must take `uart_rx_data` before the next `uart_rx_valid`, which comes at least 10·`CYCLES_PER_BIT` cycles later.

## Test plan

- **Single byte:** 0xA5 sent at 104 cycles/bit with 1 stop bit → one `uart_rx_valid` pulse, `uart_rx_data`=0xA5, `uart_rx_frame_err`=0, valid 991 cycles after the pin falling edge (±1).
- **Back-to-back:** 0x00, 0xFF, 0x55 with no idle gap → three valid pulses 1040 cycles apart, with data 0x00, 0xFF, 0x55 in order.
- **Glitch rejection:** pin low for 20 cycles, then high → no pulses, FSM back in IDLE. A following 0x3C is received correctly.
- **Framing error:** 0x3C sent with the stop bit forced 0 → `uart_rx_frame_err` pulses once, `uart_rx_break`=0, `uart_rx_valid`=0, `uart_rx_data` retains its previous value.
- **Break:** pin low for 3000 cycles → exactly one `uart_rx_frame_err` pulse with `uart_rx_break` in the same cycle, and no further pulses while the line stays low. After the line returns high, 0x81 is received correctly.
- **Reset and enable:**
  - `resetn` low for 1 cycle in the middle of bit 4 → no pulses; `uart_rx_data`=0.
  - With `uart_rx_en`=0, a frame sent → ignored.
  - `uart_rx_en` deasserted during DATA → the frame still completes with valid.
